// File: rtl/store_checker_if.sv
// ----------------------------------------------------------------------------
// store_checker_if
// Snooped data-memory write bus of the processor (MemWrite, DataAdr,
// WriteData). The processor side drives it (master); the checker only
// observes it (slave).
//   mem_write  : store strobe
//   data_adr   : store address
//   write_data : store data
// ----------------------------------------------------------------------------
interface store_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_write;
    logic [ADDR_W-1:0] data_adr;
    logic [DATA_W-1:0] write_data;

    modport master (output mem_write, output data_adr, output write_data);
    modport slave  (input  mem_write, input  data_adr, input  write_data);
endinterface

// File: rtl/store_checker.sv
// ----------------------------------------------------------------------------
// store_checker
// Snoops the processor's data-memory write bus and checks it against a
// programmed table of expected stores, either in table order or in any
// order. One scratch address may be ignored; a run that stalls times out.
// Reports a sticky pass/fail verdict with the offending store captured.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   start        : one-cycle pulse, begins a run (ignored while running)
//   cfg_we       : write table entry cfg_idx with (cfg_addr, cfg_data)
//   bus          : snooped write bus (slave modport)
//   busy         : high while a run is in progress
//   pass / fail  : sticky verdicts
//   fail_code    : 0 none, 1 unexpected address, 2 data mismatch, 3 timeout
//   fail_addr    : address of the offending store (0 on timeout)
//   fail_data    : data of the offending store (0 on timeout)
//   match_count  : table entries matched so far
//   cycle_count  : cycles spent in the current or last run
// ----------------------------------------------------------------------------
module store_checker #(
    parameter int                NUM_EXP     = 4,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter bit                ORDERED     = 1'b1,
    parameter bit                IGNORE_EN   = 1'b1,
    parameter logic [ADDR_W-1:0] IGNORE_ADDR = 96,
    parameter int                TIMEOUT     = 1000,
    localparam int               IDX_W       = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
    localparam int               MC_W        = $clog2(NUM_EXP + 1),
    localparam int               CC_W        = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    store_checker_if.slave    bus,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [MC_W-1:0]   match_count,
    output logic [CC_W-1:0]   cycle_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_table_addr [NUM_EXP];
    logic [DATA_W-1:0] r_table_data [NUM_EXP];
    logic              r_matched    [NUM_EXP];
    logic [1:0]        r_fail_code;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_data;
    logic [MC_W-1:0]   r_match_count;
    logic [CC_W-1:0]   r_cycle_count;

    logic              w_idx_ok;
    logic              w_store;
    logic              w_hit;
    logic              w_data_ok;
    logic [IDX_W-1:0]  w_hit_idx;
    logic              w_match;
    logic [MC_W-1:0]   w_mc_next;
    logic [CC_W-1:0]   w_cycle_next;
    logic              w_timeout;

    assign w_idx_ok     = {1'b0, cfg_idx} < (IDX_W + 1)'(NUM_EXP);
    assign w_store      = bus.mem_write && !(IGNORE_EN && (bus.data_adr == IGNORE_ADDR));
    assign w_match      = w_store && w_hit && w_data_ok;
    assign w_mc_next    = r_match_count + 1'b1;
    // Saturating count: holds at all-ones instead of wrapping to zero.
    assign w_cycle_next = (r_cycle_count == {CC_W{1'b1}}) ? r_cycle_count
                                                          : r_cycle_count + 1'b1;
    assign w_timeout    = w_cycle_next >= CC_W'(TIMEOUT - 1);

    // Entry lookup. w_hit means the address matched; w_data_ok then says
    // whether the data did too.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_hit     = 1'b0;
        w_data_ok = 1'b0;
        w_hit_idx = '0;
        if (ORDERED) begin
            // Only the entry at the current match position is a candidate.
            for (int i = 0; i < NUM_EXP; i++) begin
                if (MC_W'(i) == r_match_count) begin
                    w_hit     = (r_table_addr[i] == bus.data_adr);
                    w_data_ok = (r_table_data[i] == bus.write_data);
                    w_hit_idx = IDX_W'(i);
                end
            end
        end else begin
            // Scan downward so the last hit assigned is the lowest index;
            // already-matched entries are skipped, so a duplicate store misses.
            for (int i = NUM_EXP - 1; i >= 0; i--) begin
                if (!r_matched[i] && (r_table_addr[i] == bus.data_adr)) begin
                    w_hit     = 1'b1;
                    w_data_ok = (r_table_data[i] == bus.write_data);
                    w_hit_idx = IDX_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the expected-store table is a register array that reset
            // must clear, so it lives in the reset branch rather than in an
            // unreset RAM.
            for (int i = 0; i < NUM_EXP; i++) begin
                r_table_addr[i] <= '0;
                r_table_data[i] <= '0;
                r_matched[i]    <= 1'b0;
            end
            r_state       <= S_IDLE;
            r_fail_code   <= '0;
            r_fail_addr   <= '0;
            r_fail_data   <= '0;
            r_match_count <= '0;
            r_cycle_count <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            if (cfg_we && (r_state != S_RUN) && w_idx_ok) begin
                r_table_addr[cfg_idx] <= cfg_addr;
                r_table_data[cfg_idx] <= cfg_data;
            end

            if (r_state == S_RUN) begin
                r_cycle_count <= w_cycle_next;
                if (w_match) begin
                    r_matched[w_hit_idx] <= 1'b1;
                    r_match_count        <= w_mc_next;
                end
                // A store on the timeout cycle takes precedence over timeout.
                if (w_store && !w_hit) begin
                    r_state     <= S_FAIL;
                    r_fail_code <= 2'd1;
                    r_fail_addr <= bus.data_adr;
                    r_fail_data <= bus.write_data;
                end else if (w_store && !w_data_ok) begin
                    r_state     <= S_FAIL;
                    r_fail_code <= 2'd2;
                    r_fail_addr <= bus.data_adr;
                    r_fail_data <= bus.write_data;
                end else if (w_match && (w_mc_next == MC_W'(NUM_EXP))) begin
                    r_state <= S_PASS;
                end else if (w_timeout) begin
                    r_state     <= S_FAIL;
                    r_fail_code <= 2'd3;
                end
            end else if (start) begin
                // IDLE, PASS or FAIL: a new run clears all verdict state.
                for (int i = 0; i < NUM_EXP; i++) begin
                    r_matched[i] <= 1'b0;
                end
                r_state       <= S_RUN;
                r_fail_code   <= '0;
                r_fail_addr   <= '0;
                r_fail_data   <= '0;
                r_match_count <= '0;
                r_cycle_count <= '0;
            end
        end
    end

    assign busy        = (r_state == S_RUN);
    assign pass        = (r_state == S_PASS);
    assign fail        = (r_state == S_FAIL);
    assign fail_code   = r_fail_code;
    assign fail_addr   = r_fail_addr;
    assign fail_data   = r_fail_data;
    assign match_count = r_match_count;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_store_checker.sv
// ----------------------------------------------------------------------------
// tb_store_checker
// Three checkers share one stimulus stream:
//   u_a : 1 entry,  in order, TIMEOUT 10   (ignore/pass, data mismatch, timeout)
//   u_b : 2 entries, any order              (unordered pass, duplicate store)
//   u_c : 2 entries, in order               (out-of-order, cfg in RUN, reset)
// Each scenario starts from reset so every checker restarts from IDLE.
// ----------------------------------------------------------------------------
module tb_store_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cfg_we;
    logic [0:0]  cfg_idx;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_data;

    store_checker_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    logic        a_busy, a_pass, a_fail;
    logic [1:0]  a_code;
    logic [31:0] a_faddr, a_fdata;
    logic [0:0]  a_mc;
    logic [3:0]  a_cc;

    logic        b_busy, b_pass, b_fail;
    logic [1:0]  b_code;
    logic [31:0] b_faddr, b_fdata;
    logic [1:0]  b_mc;
    logic [9:0]  b_cc;

    logic        c_busy, c_pass, c_fail;
    logic [1:0]  c_code;
    logic [31:0] c_faddr, c_fdata;
    logic [1:0]  c_mc;
    logic [9:0]  c_cc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    store_checker #(.NUM_EXP(1), .ORDERED(1'b1), .TIMEOUT(10)) u_a (
        .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .bus(bus.slave),
        .busy(a_busy), .pass(a_pass), .fail(a_fail), .fail_code(a_code),
        .fail_addr(a_faddr), .fail_data(a_fdata), .match_count(a_mc), .cycle_count(a_cc)
    );

    store_checker #(.NUM_EXP(2), .ORDERED(1'b0), .TIMEOUT(1000)) u_b (
        .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .bus(bus.slave),
        .busy(b_busy), .pass(b_pass), .fail(b_fail), .fail_code(b_code),
        .fail_addr(b_faddr), .fail_data(b_fdata), .match_count(b_mc), .cycle_count(b_cc)
    );

    store_checker #(.NUM_EXP(2), .ORDERED(1'b1), .TIMEOUT(1000)) u_c (
        .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .bus(bus.slave),
        .busy(c_busy), .pass(c_pass), .fail(c_fail), .fail_code(c_code),
        .fail_addr(c_faddr), .fail_data(c_fdata), .match_count(c_mc), .cycle_count(c_cc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are stable 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        cfg_we = 1'b0;
        bus.mem_write = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic cfg(input logic [0:0] idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1;
        cfg_idx = idx;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.mem_write = 1'b1;
        bus.data_adr = a;
        bus.write_data = d;
        tick();
        bus.mem_write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        cfg_we = 1'b0;
        cfg_idx = '0;
        cfg_addr = '0;
        cfg_data = '0;
        bus.mem_write = 1'b0;
        bus.data_adr = '0;
        bus.write_data = '0;
        #2;
        check("rst_busy", a_busy, 0);
        check("rst_pass", a_pass, 0);
        check("rst_fail", a_fail, 0);
        check("rst_code", a_code, 0);
        check("rst_mc",   a_mc, 0);
        check("rst_cc",   a_cc, 0);

        // Ignored scratch store, then a matching store completes the table.
        do_reset();
        cfg(0, 100, 25);
        go();
        check("t1_busy", a_busy, 1);
        store(96, 7);
        check("t1_ign_pass", a_pass, 0);
        check("t1_ign_mc",   a_mc, 0);
        check("t1_ign_busy", a_busy, 1);
        store(100, 25);
        check("t1_pass", a_pass, 1);
        check("t1_busy_lo", a_busy, 0);
        check("t1_mc", a_mc, 1);
        check("t1_fail", a_fail, 0);
        check("t1_cc", a_cc, 2);

        // In-order checker sees entry 1 first: unexpected address.
        do_reset();
        cfg(0, 80, 1);
        cfg(1, 84, 2);
        go();
        store(84, 2);
        check("t2_fail",  c_fail, 1);
        check("t2_code",  c_code, 1);
        check("t2_faddr", c_faddr, 84);
        check("t2_fdata", c_fdata, 2);
        check("t2_mc",    c_mc, 0);

        // Any-order checker accepts the reversed stores; then duplicate fails.
        do_reset();
        cfg(0, 80, 1);
        cfg(1, 84, 2);
        go();
        store(84, 2);
        check("t3_mc1",  b_mc, 1);
        check("t3_busy", b_busy, 1);
        store(80, 1);
        check("t3_pass", b_pass, 1);
        check("t3_mc2",  b_mc, 2);
        go();
        check("t3_restart_pass", b_pass, 0);
        check("t3_restart_mc",   b_mc, 0);
        store(84, 2);
        check("t3_dup_first", b_fail, 0);
        store(84, 2);
        check("t3_dup_fail",  b_fail, 1);
        check("t3_dup_code",  b_code, 1);
        check("t3_dup_faddr", b_faddr, 84);
        check("t3_dup_mc",    b_mc, 1);

        // Right address, wrong data.
        do_reset();
        cfg(0, 100, 25);
        go();
        store(100, 24);
        check("t4_fail",  a_fail, 1);
        check("t4_code",  a_code, 2);
        check("t4_faddr", a_faddr, 100);
        check("t4_fdata", a_fdata, 24);

        // Timeout with TIMEOUT=10: FAIL on the 9th RUN edge, cycle_count 9.
        do_reset();
        cfg(0, 100, 25);
        go();
        check("t5_cc0", a_cc, 0);
        idle(8);
        check("t5_cc8",   a_cc, 8);
        check("t5_busy8", a_busy, 1);
        idle(1);
        check("t5_to_fail",  a_fail, 1);
        check("t5_to_code",  a_code, 3);
        check("t5_to_cc",    a_cc, 9);
        check("t5_to_faddr", a_faddr, 0);
        check("t5_to_fdata", a_fdata, 0);
        // Matching store on the timeout edge wins.
        go();
        check("t5_rerun_fail", a_fail, 0);
        idle(8);
        store(100, 25);
        check("t5_edge_pass", a_pass, 1);
        check("t5_edge_fail", a_fail, 0);
        check("t5_edge_cc",   a_cc, 9);
        // Mismatching store on the timeout edge reports code 2, not 3.
        go();
        idle(8);
        store(100, 1);
        check("t5_edge_code", a_code, 2);
        check("t5_edge_fdata", a_fdata, 1);

        // cfg_we during RUN is ignored; then reset mid-run clears everything.
        do_reset();
        cfg(0, 80, 1);
        cfg(1, 84, 2);
        go();
        store(80, 1);
        cfg(1, 99, 9);
        store(84, 2);
        check("t6_cfg_run_pass", c_pass, 1);
        check("t6_cfg_run_mc",   c_mc, 2);
        go();
        store(80, 1);
        check("t6_mid_mc", c_mc, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_rst_busy", c_busy, 0);
        check("t6_rst_pass", c_pass, 0);
        check("t6_rst_fail", c_fail, 0);
        check("t6_rst_mc",   c_mc, 0);
        check("t6_rst_cc",   c_cc, 0);
        tick();
        rst = 1'b1;
        tick();
        // Table was cleared: the once-expected store is now unexpected.
        go();
        store(80, 1);
        check("t6_tbl_clr_fail", c_fail, 1);
        check("t6_tbl_clr_code", c_code, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
